// File: rtl/execute_param.sv
// execute_param: parametrised execute stage with registered results, a
// one-cycle result-valid strobe and an optional iterative shift-add multiplier.
//
// Ports
//   clock              system clock, all state updates on the rising edge
//   reset              synchronous, active-low
//   enable_ex          issue strobe; accepted only while busy is low
//   src1, src2, imm    operand A, operand B / store data, sign-extended immediate
//   control_in         {imm_sel, opselect[1:0], operation[2:0]}
//   mem_data_read_in   load data for the current mem_addr
//   mem_addr           combinational src1 + B (load/store address)
//   mem_data_write_out registered store data
//   mem_write_en       registered one-cycle store pulse
//   aluout, carry      registered result and flag
//   mul_hi             registered upper half of the last product
//   out_valid          one-cycle pulse when aluout/carry/mul_hi were updated
//   busy               multiply in progress, new issues are dropped
module execute_param #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_ex,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] imm,
  input  logic [5:0]       control_in,
  input  logic [WIDTH-1:0] mem_data_read_in,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data_write_out,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] aluout,
  output logic             carry,
  output logic [WIDTH-1:0] mul_hi,
  output logic             out_valid,
  output logic             busy
);

  localparam int SHIFT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHIFT_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   aluout_q, aluout_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   mul_hi_q, mul_hi_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic               imm_sel_s;
  logic [1:0]         opsel_s;
  logic [2:0]         op_s;
  logic [WIDTH-1:0]   b_s;
  logic               issue_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [SHIFT_W-1:0] shamt_s;
  logic [WIDTH:0]     sll_s;
  logic [WIDTH:0]     srl_s;
  logic [WIDTH:0]     sra_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH-1:0]   step_hi_s;
  logic [WIDTH-1:0]   step_lo_s;

  assign imm_sel_s = control_in[5];
  assign opsel_s   = control_in[4:3];
  assign op_s      = control_in[2:0];
  assign b_s       = imm_sel_s ? imm : src2;
  assign issue_s   = enable_ex & ~busy_q & reset;

  assign sum_s  = {1'b0, src1} + {1'b0, b_s};
  // Two's-complement subtract; the carry out is the "no borrow" flag.
  assign diff_s = {1'b0, src1} + {1'b0, ~b_s} + {{WIDTH{1'b0}}, 1'b1};
  assign mem_addr = sum_s[WIDTH-1:0];

  // Shifts are done one bit wider so the last bit shifted out lands in the
  // extra bit; for a zero amount that extra bit is the zero padding.
  assign shamt_s = b_s[SHIFT_W-1:0];
  assign sll_s   = {1'b0, src1} << shamt_s;
  assign srl_s   = {src1, 1'b0} >> shamt_s;
  assign sra_s   = $signed({src1, 1'b0}) >>> shamt_s;

  // One shift-add step: add the multiplicand if the current multiplier bit
  // is set, then shift {hi, lo} right; lo gradually fills with product bits.
  assign mul_sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign step_hi_s = mul_sum_s[WIDTH:1];
  assign step_lo_s = {mul_sum_s[0], acc_lo_q[WIDTH-1:1]};

  // Next-state and next-output computation for issue and multiply sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    aluout_d    = aluout_q;
    carry_d     = carry_q;
    mul_hi_d    = mul_hi_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          out_valid_d = 1'b1;
          case (opsel_s)
            2'b00: begin
              carry_d = 1'b0;
              case (op_s)
                3'b000: {carry_d, aluout_d} = sum_s;
                3'b001: {carry_d, aluout_d} = diff_s;
                3'b010: aluout_d = src1 & b_s;
                3'b011: aluout_d = src1 | b_s;
                3'b100: aluout_d = src1 ^ b_s;
                3'b101: aluout_d = ~src1;
                3'b110: aluout_d = b_s;
                3'b111: aluout_d = src1;
                default: aluout_d = src1;
              endcase
            end
            2'b01: begin
              case (op_s)
                3'b001: begin
                  aluout_d = srl_s[WIDTH:1];
                  carry_d  = srl_s[0];
                end
                3'b010: begin
                  aluout_d = sra_s[WIDTH:1];
                  carry_d  = sra_s[0];
                end
                default: begin
                  aluout_d = sll_s[WIDTH-1:0];
                  carry_d  = sll_s[WIDTH];
                end
              endcase
            end
            2'b10: begin
              carry_d = 1'b0;
              case (op_s)
                3'b000: aluout_d = mem_data_read_in;
                3'b001: begin
                  aluout_d = sum_s[WIDTH-1:0];
                  wdata_d  = src2;
                  we_d     = 1'b1;
                end
                default: aluout_d = sum_s[WIDTH-1:0];
              endcase
            end
            2'b11: begin
              if (MUL_EN) begin
                // Result is reported when the last iteration retires.
                out_valid_d = 1'b0;
                state_d     = ST_MUL;
                busy_d      = 1'b1;
                cnt_d       = {CNT_W{1'b0}};
                mcand_d     = src1;
                acc_hi_d    = {WIDTH{1'b0}};
                acc_lo_d    = b_s;
              end else begin
                // NOP: results hold, only the valid strobe fires.
                aluout_d = aluout_q;
              end
            end
            default: begin
              out_valid_d = 1'b0;
            end
          endcase
        end else begin
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        acc_hi_d = step_hi_s;
        acc_lo_d = step_lo_s;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          aluout_d    = step_lo_s;
          mul_hi_d    = step_hi_s;
          carry_d     = |step_hi_s;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      mcand_q     <= {WIDTH{1'b0}};
      acc_hi_q    <= {WIDTH{1'b0}};
      acc_lo_q    <= {WIDTH{1'b0}};
      aluout_q    <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      mul_hi_q    <= {WIDTH{1'b0}};
      wdata_q     <= {WIDTH{1'b0}};
      we_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      aluout_q    <= aluout_d;
      carry_q     <= carry_d;
      mul_hi_q    <= mul_hi_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign aluout             = aluout_q;
  assign carry              = carry_q;
  assign mul_hi             = mul_hi_q;
  assign mem_data_write_out = wdata_q;
  assign mem_write_en       = we_q;
  assign out_valid          = out_valid_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_execute_param.sv
// Scoreboard bench for execute_param (WIDTH=16, MUL_EN=1): stimulus pushes
// hand-computed expected results, a negedge monitor pops on every out_valid.
module tb_execute_param;

  logic        clock;
  logic        reset;
  logic        enable_ex;
  logic [15:0] src1, src2, imm, mem_data_read_in;
  logic [5:0]  control_in;
  logic [15:0] mem_addr, mem_data_write_out, aluout, mul_hi;
  logic        mem_write_en, carry, out_valid, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] alu;
    logic        c;
    logic [15:0] hi;
    logic        we;
    logic [15:0] wd;
  } exp_t;

  exp_t sb[$];

  execute_param #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .enable_ex(enable_ex),
    .src1(src1), .src2(src2), .imm(imm), .control_in(control_in),
    .mem_data_read_in(mem_data_read_in), .mem_addr(mem_addr),
    .mem_data_write_out(mem_data_write_out), .mem_write_en(mem_write_en),
    .aluout(aluout), .carry(carry), .mul_hi(mul_hi),
    .out_valid(out_valid), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_aluout"}, {16'h0, aluout}, {16'h0, e.alu});
          chk({e.name, "_carry"}, {31'h0, carry}, {31'h0, e.c});
          chk({e.name, "_mul_hi"}, {16'h0, mul_hi}, {16'h0, e.hi});
          chk({e.name, "_we"}, {31'h0, mem_write_en}, {31'h0, e.we});
          if (e.we) chk({e.name, "_wdata"}, {16'h0, mem_data_write_out}, {16'h0, e.wd});
        end
      end else if (mem_write_en === 1'b1) begin
        chk("stray_mem_write_en", 32'd1, 32'd0);
      end
    end
  end

  logic [15:0] last_addr;

  // Drive one instruction for exactly one issue edge.
  task automatic issue(input logic [5:0] ctrl, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] im);
    @(negedge clock);
    control_in = ctrl;
    src1       = a;
    src2       = b;
    imm        = im;
    enable_ex  = 1'b1;
    #1 last_addr = mem_addr;
    @(negedge clock);
    enable_ex = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [15:0] alu, input logic c,
                            input logic [15:0] hi, input logic we, input logic [15:0] wd);
    exp_t e;
    e.name = name; e.alu = alu; e.c = c; e.hi = hi; e.we = we; e.wd = wd;
    sb.push_back(e);
  endtask

  int bc;

  initial begin
    reset = 1'b0; enable_ex = 1'b0; src1 = 16'h0; src2 = 16'h0; imm = 16'h0;
    control_in = 6'h0; mem_data_read_in = 16'h0;
    repeat (2) @(negedge clock);
    chk("rst_aluout", {16'h0, aluout}, 32'h0);
    chk("rst_carry", {31'h0, carry}, 32'h0);
    chk("rst_mul_hi", {16'h0, mul_hi}, 32'h0);
    chk("rst_flags", {28'h0, out_valid, busy, mem_write_en, 1'b0}, 32'h0);
    chk("rst_wdata", {16'h0, mem_data_write_out}, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Arithmetic / logic
    expect_res("add", 16'h0000, 1'b1, 16'h0, 1'b0, 16'h0);
    issue(6'b0_00_000, 16'hFFFF, 16'h0001, 16'h0);
    expect_res("sub_imm", 16'hFFFE, 1'b0, 16'h0, 1'b0, 16'h0);
    issue(6'b1_00_001, 16'h0005, 16'h1111, 16'h0007);
    expect_res("and", 16'h3030, 1'b0, 16'h0, 1'b0, 16'h0);
    issue(6'b0_00_010, 16'hF0F0, 16'h3C3C, 16'h0);
    expect_res("xor", 16'hCCCC, 1'b0, 16'h0, 1'b0, 16'h0);
    issue(6'b0_00_100, 16'hF0F0, 16'h3C3C, 16'h0);
    expect_res("not_a", 16'h0F0F, 1'b0, 16'h0, 1'b0, 16'h0);
    issue(6'b0_00_101, 16'hF0F0, 16'h3C3C, 16'h0);
    expect_res("pass_b", 16'h3C3C, 1'b0, 16'h0, 1'b0, 16'h0);
    issue(6'b0_00_110, 16'hF0F0, 16'h3C3C, 16'h0);

    // Shifts
    expect_res("sra1", 16'hC000, 1'b1, 16'h0, 1'b0, 16'h0);
    issue(6'b0_01_010, 16'h8001, 16'h0001, 16'h0);
    expect_res("sll0", 16'h8001, 1'b0, 16'h0, 1'b0, 16'h0);
    issue(6'b0_01_000, 16'h8001, 16'h0000, 16'h0);
    expect_res("srl15", 16'h0001, 1'b0, 16'h0, 1'b0, 16'h0);
    issue(6'b0_01_001, 16'h8001, 16'h000F, 16'h0);
    expect_res("sll1", 16'h0002, 1'b1, 16'h0, 1'b0, 16'h0);
    issue(6'b0_01_000, 16'h8001, 16'h0001, 16'h0);

    // Multiply 0100*0100 with an ADD dropped mid-busy
    expect_res("mul_a", 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0);
    issue(6'b0_11_000, 16'h0100, 16'h0100, 16'h0);
    bc = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy !== 1'b1) break;
      bc++;
      if (k == 3) begin
        control_in = 6'b0_00_000; src1 = 16'h1111; src2 = 16'h2222; enable_ex = 1'b1;
      end
      if (k == 4) enable_ex = 1'b0;
      @(negedge clock);
    end
    chk("mul_busy_cycles", bc, 32'd16);

    expect_res("mul_b", 16'h0001, 1'b1, 16'hFFFE, 1'b0, 16'h0);
    issue(6'b0_11_000, 16'hFFFF, 16'hFFFF, 16'h0);
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      @(negedge clock);
    end
    chk("mul_b_busy_cycles", bc, 32'd16);

    // Memory
    expect_res("store", 16'h3004, 1'b0, 16'hFFFE, 1'b1, 16'hBEEF);
    issue(6'b1_10_001, 16'h3000, 16'hBEEF, 16'h0004);
    chk("store_mem_addr", {16'h0, last_addr}, 32'h3004);
    mem_data_read_in = 16'h1234;
    expect_res("load", 16'h1234, 1'b0, 16'hFFFE, 1'b0, 16'h0);
    issue(6'b0_10_000, 16'h0040, 16'h0002, 16'h0);

    // Reset during multiply: aborted, no result
    issue(6'b0_11_000, 16'h0003, 16'h0005, 16'h0);
    repeat (4) @(negedge clock);
    chk("abort_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_aluout", {16'h0, aluout}, 32'h0);
    chk("abort_mul_hi", {16'h0, mul_hi}, 32'h0);
    chk("abort_flags", {28'h0, out_valid, busy, mem_write_en, carry}, 32'h0);
    chk("abort_wdata", {16'h0, mem_data_write_out}, 32'h0);
    reset = 1'b1;
    expect_res("add_after_rst", 16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0);
    issue(6'b0_00_000, 16'h0002, 16'h0003, 16'h0);

    repeat (20) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
